// File: rtl/vme_pkg.sv
// -----------------------------------------------------------------------------
// vme_pkg
// Shared definitions for the VME bus-error watchdog.
//   bus_timer_state_t : FSM state encoding used by vme_bus_timer.
//   VME_BTO_CYCLES    : default strobe-to-acknowledge allowance in clocks.
//   VME_ERR_W         : default width of the bus-error event counter.
//   vme_ds_active()   : true when either data strobe is asserted (active low).
// -----------------------------------------------------------------------------
package vme_pkg;

    localparam int VME_BTO_CYCLES = 64;
    localparam int VME_ERR_W      = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_DS  = 3'd1,
        WAIT_ACK = 3'd2,
        BERR     = 3'd3,
        RELEASE  = 3'd4
    } bus_timer_state_t;

    function automatic logic vme_ds_active(input logic ds0_n, input logic ds1_n);
        return (!ds0_n) || (!ds1_n);
    endfunction

endpackage

// File: rtl/vme_sat_counter.sv
// -----------------------------------------------------------------------------
// vme_sat_counter
// Up-counter with increment enable that stops at its all-ones value and never
// wraps. Synchronous active-high reset clears it to zero.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous reset, active high
//   inc   in  1  increment request for this clock
//   count out W  current count
// -----------------------------------------------------------------------------
module vme_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != COUNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vme_bus_timer.sv
// -----------------------------------------------------------------------------
// vme_bus_timer
// VME bus-error watchdog. Times each strobed data-transfer cycle from data
// strobe assertion to dtack_n; when the slave fails to acknowledge within
// TIMEOUT_CYCLES clocks it drives berr_n low until the master drops all
// strobes, and counts the event in a saturating counter.
//
// Parameters:
//   TIMEOUT_CYCLES  clocks allowed from data strobe to dtack_n (2..2^CNT_W)
//   CNT_W           width of the timeout counter
//   ERR_W           width of the bus-error event counter
// Ports:
//   clk            in   1      system clock, rising edge
//   rst            in   1      synchronous reset, active high
//   as_n           in   1      address strobe, active low
//   ds0_n, ds1_n   in   1      data strobes, active low
//   dtack_n        in   1      slave acknowledge, active low
//   berr_n         out  1      bus error, active low, registered
//   timeout_pulse  out  1      one-clock pulse on bus-error entry
//   busy           out  1      high whenever the FSM is not IDLE
//   err_count      out  ERR_W  saturating bus-error count since reset
// Optional build macro VME_BUS_TIMER_ADDR_LOG_EN adds:
//   address        in   32     bus address of the current cycle
//   err_addr       out  32     address captured at the last bus-error entry
// -----------------------------------------------------------------------------
module vme_bus_timer
    import vme_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = VME_BTO_CYCLES,
    parameter int CNT_W          = 8,
    parameter int ERR_W          = VME_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             as_n,
    input  logic             ds0_n,
    input  logic             ds1_n,
    input  logic             dtack_n,
    output logic             berr_n,
    output logic             timeout_pulse,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
    ,
    input  logic [31:0]      address,
    output logic [31:0]      err_addr
`endif
);

    // Counter value seen in the last allowed cycle; the next edge without an
    // acknowledge enters BERR. TIMEOUT_CYCLES may equal 2^CNT_W, so the
    // subtraction is done before truncation.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bus_timer_state_t state_q;
    bus_timer_state_t state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             berr_n_q;
    logic             berr_n_d;
    logic             timeout_pulse_q;
    logic             timeout_pulse_d;

    logic             ds_act;
    logic             strobes_off;
    logic             enter_berr;

    assign ds_act      = vme_ds_active(ds0_n, ds1_n);
    assign strobes_off = as_n & ds0_n & ds1_n;

    // -------------------------------------------------------------------------
    // Next-state, timeout counter and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_berr = 1'b0;

        case (state_q)
            IDLE: begin
                if (!as_n) begin
                    if (ds_act) begin
                        state_d = WAIT_ACK;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_DS;
                    end
                end
            end

            WAIT_DS: begin
                // Address strobe dropped without a data phase: nothing to time.
                if (as_n) begin
                    state_d = IDLE;
                end else if (ds_act) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end

            WAIT_ACK: begin
                // Acknowledge beats abort, abort beats timeout, so a dtack_n
                // arriving in the final allowed cycle never raises an error.
                if (!dtack_n) begin
                    state_d = RELEASE;
                end else if (as_n) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = BERR;
                    enter_berr = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            BERR: begin
                // dtack_n is deliberately ignored; only the master can end it.
                if (strobes_off) begin
                    state_d = IDLE;
                end
            end

            RELEASE: begin
                if (strobes_off) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // berr_n is registered from the next state so it tracks BERR exactly,
        // asserting on the entry edge and releasing on the exit edge.
        berr_n_d        = (state_d != BERR);
        timeout_pulse_d = enter_berr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            berr_n_q        <= 1'b1;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            berr_n_q        <= berr_n_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign berr_n        = berr_n_q;
    assign timeout_pulse = timeout_pulse_q;
    assign busy          = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // Bus-error event counter
    // -------------------------------------------------------------------------
    vme_sat_counter #(
        .W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (enter_berr),
        .count (err_count)
    );

`ifdef VME_BUS_TIMER_ADDR_LOG_EN
    // -------------------------------------------------------------------------
    // Address of the cycle that last timed out
    // -------------------------------------------------------------------------
    logic [31:0] err_addr_q;
    logic [31:0] err_addr_d;

    always_comb begin
        err_addr_d = err_addr_q;
        if (enter_berr) begin
            err_addr_d = address;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q <= '0;
        end else begin
            err_addr_q <= err_addr_d;
        end
    end

    assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_vme_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_vme_bus_timer
// Directed bench for vme_bus_timer with TIMEOUT_CYCLES=16 and ERR_W=2.
// A behavioural model tracks the bus cycle in terms of elapsed clocks since
// the data strobe and checks every DUT output after every clock edge; the
// directed sequences add hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_vme_bus_timer;

    localparam int T       = 16;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic             as_n;
    logic             ds0_n;
    logic             ds1_n;
    logic             dtack_n;
    logic             berr_n;
    logic             timeout_pulse;
    logic             busy;
    logic [ERR_W-1:0] err_count;
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
    logic [31:0]      address;
    logic [31:0]      err_addr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    vme_bus_timer #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8),
        .ERR_W          (ERR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .as_n          (as_n),
        .ds0_n         (ds0_n),
        .ds1_n         (ds1_n),
        .dtack_n       (dtack_n),
        .berr_n        (berr_n),
        .timeout_pulse (timeout_pulse),
        .busy          (busy),
        .err_count     (err_count)
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        ,
        .address       (address),
        .err_addr      (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: the bus cycle seen as elapsed clocks since the data
    // strobe (m_elapsed, -1 when not timing), an address-only phase, and a
    // hold phase that lasts until every strobe is released.
    // -------------------------------------------------------------------------
    int          m_elapsed   = -1;
    bit          m_addr_only = 1'b0;
    bit          m_hold      = 1'b0;
    bit          m_error     = 1'b0;
    bit          m_pulse     = 1'b0;
    int          m_errs      = 0;
    logic [31:0] m_addr      = '0;

    always @(posedge clk) begin
        logic any_ds;
        logic all_off;
        any_ds  = !ds0_n || !ds1_n;
        all_off = as_n && ds0_n && ds1_n;
        m_pulse = 1'b0;
        if (rst) begin
            m_elapsed   = -1;
            m_addr_only = 1'b0;
            m_hold      = 1'b0;
            m_error     = 1'b0;
            m_errs      = 0;
            m_addr      = '0;
        end else if (m_hold) begin
            if (all_off) begin
                m_hold  = 1'b0;
                m_error = 1'b0;
            end
        end else if (m_elapsed >= 0) begin
            if (!dtack_n) begin
                m_elapsed = -1;
                m_hold    = 1'b1;
            end else if (as_n) begin
                m_elapsed = -1;
            end else if (m_elapsed == T - 1) begin
                m_elapsed = -1;
                m_hold    = 1'b1;
                m_error   = 1'b1;
                m_pulse   = 1'b1;
                if (m_errs < ERR_MAX) m_errs++;
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
                m_addr = address;
`endif
            end else begin
                m_elapsed++;
            end
        end else if (m_addr_only) begin
            if (as_n) begin
                m_addr_only = 1'b0;
            end else if (any_ds) begin
                m_addr_only = 1'b0;
                m_elapsed   = 0;
            end
        end else if (!as_n) begin
            if (any_ds) m_elapsed = 0;
            else        m_addr_only = 1'b1;
        end

        #1;
        check("model_berr_n", 32'(berr_n), 32'(!m_error));
        check("model_timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        check("model_busy", 32'(busy), 32'(m_hold || m_addr_only || (m_elapsed >= 0)));
        check("model_err_count", 32'(err_count), 32'(m_errs));
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        check("model_err_addr", err_addr, m_addr);
`endif
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge, literal checks are
    // taken 2 time units after a rising edge.
    // -------------------------------------------------------------------------
    task automatic set_bus(input logic a, input logic d0, input logic d1, input logic dk);
        @(negedge clk);
        as_n    = a;
        ds0_n   = d0;
        ds1_n   = d1;
        dtack_n = dk;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        edges(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Full timeout cycle: strobe, no acknowledge, release after BERR entry.
    task automatic force_timeout(input int idx, input int exp_count);
        set_bus(1'b0, 1'b0, 1'b1, 1'b1);
        edges(T + 1);
        check($sformatf("sat_timeout%0d_berr_n", idx), 32'(berr_n), 32'd0);
        check($sformatf("sat_timeout%0d_count", idx), 32'(err_count), 32'(exp_count));
        $display("timeout %0d: err_count=%0d", idx, err_count);
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(2);
    endtask

    initial begin
        rst     = 1'b1;
        as_n    = 1'b1;
        ds0_n   = 1'b1;
        ds1_n   = 1'b1;
        dtack_n = 1'b1;
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        address = 32'h0;
`endif
        edges(3);
        @(negedge clk);
        rst = 1'b0;
        edges(1);
        check("reset_berr_n", 32'(berr_n), 32'd1);
        check("reset_pulse", 32'(timeout_pulse), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        $display("reset: berr_n=%0b busy=%0b err_count=%0d", berr_n, busy, err_count);

        // --- Timeout: strobe at edge k, berr_n low after edge k+16 ----------
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        @(negedge clk);
        address = 32'h0000_4A10;
`endif
        set_bus(1'b0, 1'b0, 1'b1, 1'b1);
        edges(1);
        check("to_busy_at_k", 32'(busy), 32'd1);
        edges(T - 1);
        check("to_berr_n_at_k+15", 32'(berr_n), 32'd1);
        check("to_pulse_at_k+15", 32'(timeout_pulse), 32'd0);
        edges(1);
        check("to_berr_n_at_k+16", 32'(berr_n), 32'd0);
        check("to_pulse_at_k+16", 32'(timeout_pulse), 32'd1);
        check("to_err_count", 32'(err_count), 32'd1);
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        check("to_err_addr", err_addr, 32'h0000_4A10);
`endif
        edges(1);
        check("to_pulse_at_k+17", 32'(timeout_pulse), 32'd0);
        check("to_berr_n_at_k+17", 32'(berr_n), 32'd0);
        set_bus(1'b1, 1'b1, 1'b1, 1'b0);
        edges(1);
        check("to_release_berr_n", 32'(berr_n), 32'd1);
        check("to_release_busy", 32'(busy), 32'd0);
        $display("timeout: berr_n=%0b busy=%0b err_count=%0d", berr_n, busy, err_count);
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(1);

        // --- Acknowledge after 5 clocks on ds1_n --------------------------
        do_reset();
        set_bus(1'b0, 1'b1, 1'b0, 1'b1);
        edges(5);
        set_bus(1'b0, 1'b1, 1'b0, 1'b0);
        edges(1);
        check("ack_berr_n", 32'(berr_n), 32'd1);
        check("ack_busy_release", 32'(busy), 32'd1);
        edges(T + 4);
        check("ack_still_release", 32'(busy), 32'd1);
        check("ack_no_error", 32'(berr_n), 32'd1);
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(1);
        check("ack_idle", 32'(busy), 32'd0);
        check("ack_err_count", 32'(err_count), 32'd0);
        $display("ack: busy=%0b err_count=%0d", busy, err_count);

        // --- Acknowledge in the last allowed cycle (cnt==15) --------------
        set_bus(1'b0, 1'b0, 1'b0, 1'b1);
        edges(T);
        set_bus(1'b0, 1'b0, 1'b0, 1'b0);
        edges(1);
        check("edge_ack_berr_n", 32'(berr_n), 32'd1);
        check("edge_ack_pulse", 32'(timeout_pulse), 32'd0);
        check("edge_ack_busy", 32'(busy), 32'd1);
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(2);
        check("edge_ack_err_count", 32'(err_count), 32'd0);
        $display("last-cycle ack: berr_n=%0b err_count=%0d", berr_n, err_count);

        // --- Address-only cycle for 40 clocks ----------------------------
        set_bus(1'b0, 1'b1, 1'b1, 1'b1);
        edges(40);
        check("addr_only_busy", 32'(busy), 32'd1);
        check("addr_only_berr_n", 32'(berr_n), 32'd1);
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(1);
        check("addr_only_idle", 32'(busy), 32'd0);
        $display("address-only: berr_n=%0b busy=%0b", berr_n, busy);

        // --- Master abort at cnt==7 ---------------------------------------
        set_bus(1'b0, 1'b0, 1'b0, 1'b1);
        edges(8);
        set_bus(1'b1, 1'b0, 1'b0, 1'b1);
        edges(1);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_berr_n", 32'(berr_n), 32'd1);
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(T + 2);
        check("abort_err_count", 32'(err_count), 32'd0);
        $display("abort: busy=%0b err_count=%0d", busy, err_count);

        // --- Saturation with ERR_W=2: 1,2,3,3,3 ---------------------------
        do_reset();
        force_timeout(1, 1);
        force_timeout(2, 2);
        force_timeout(3, 3);
        force_timeout(4, 3);
        force_timeout(5, 3);

        // --- Reset while in BERR ------------------------------------------
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        @(negedge clk);
        address = 32'h0000_1234;
`endif
        set_bus(1'b0, 1'b0, 1'b1, 1'b1);
        edges(T + 2);
        check("rst_berr_pre_berr_n", 32'(berr_n), 32'd0);
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        check("rst_berr_pre_err_addr", err_addr, 32'h0000_1234);
`endif
        @(negedge clk);
        rst = 1'b1;
        edges(1);
        check("rst_berr_berr_n", 32'(berr_n), 32'd1);
        check("rst_berr_err_count", 32'(err_count), 32'd0);
        check("rst_berr_busy", 32'(busy), 32'd0);
`ifdef VME_BUS_TIMER_ADDR_LOG_EN
        check("rst_berr_err_addr", err_addr, 32'h0);
`endif
        $display("reset in BERR: berr_n=%0b err_count=%0d", berr_n, err_count);
        @(negedge clk);
        rst = 1'b0;
        set_bus(1'b1, 1'b1, 1'b1, 1'b1);
        edges(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
